// File: rtl/alu_pkg.sv
// Shared ALU result-stage definitions: op encodings,
// flag bit positions and default widths.
package alu_pkg;
  localparam int DW_DEF  = 32;
  localparam int OPW_DEF = 3;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_SHL = 3'd5;
  localparam logic [2:0] OP_SHR = 3'd6;
  localparam logic [2:0] OP_CHK = 3'd7;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;
endpackage

// File: rtl/alu_result_stage_if.sv
// Upstream/downstream handshake bundle for the ALU
// result stage; master drives beats, slave is the stage.
interface alu_result_stage_if #(
  parameter int DW  = alu_pkg::DW_DEF,
  parameter int OPW = alu_pkg::OPW_DEF
);
  logic           in_valid;
  logic           in_ready;
  logic [OPW-1:0] op_sel;
  logic           set_flags;
  logic [DW-1:0]  add_out;
  logic [DW-1:0]  sub_out;
  logic [DW-1:0]  and_out;
  logic [DW-1:0]  or_out;
  logic [DW-1:0]  xor_out;
  logic [DW-1:0]  sfl_out;
  logic [DW-1:0]  sfr_out;
  logic [DW-1:0]  chk_out;
  logic           cf_in;
  logic           vf_in;
  logic           out_valid;
  logic           out_ready;
  logic [DW-1:0]  result;
  logic [3:0]     flags_out;

  modport master (
    output in_valid, op_sel, set_flags,
    output add_out, sub_out, and_out, or_out,
    output xor_out, sfl_out, sfr_out, chk_out,
    output cf_in, vf_in, out_ready,
    input  in_ready, out_valid, result, flags_out
  );

  modport slave (
    input  in_valid, op_sel, set_flags,
    input  add_out, sub_out, and_out, or_out,
    input  xor_out, sfl_out, sfr_out, chk_out,
    input  cf_in, vf_in, out_ready,
    output in_ready, out_valid, result, flags_out
  );
endinterface

// File: rtl/alu_skid_buf.sv
// Two-entry in-order queue with a registered in_ready,
// so out_ready never reaches in_ready combinationally.
module alu_skid_buf #(
  parameter int W = 36
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);
  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] ONE   = 2'd1;
  localparam logic [1:0] FULL  = 2'd2;

  logic [1:0]   state;
  logic [1:0]   state_n;
  logic [W-1:0] head;
  logic [W-1:0] tail;
  logic         acc;
  logic         xfer;

  assign acc       = in_valid && in_ready;
  assign xfer      = out_valid && out_ready;
  assign out_valid = (state != EMPTY);
  assign out_data  = head;

  always_comb begin
    state_n = state;
    unique case (state)
      EMPTY: if (acc) state_n = ONE;
      ONE: begin
        if (acc && !xfer)      state_n = FULL;
        else if (xfer && !acc) state_n = EMPTY;
      end
      FULL:  if (xfer) state_n = ONE;
      default: state_n = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= EMPTY;
      in_ready <= 1'b0;
      head     <= '0;
      tail     <= '0;
    end else begin
      state    <= state_n;
      in_ready <= (state_n != FULL);
      // ONE with accept+transfer: new beat replaces head
      if ((state == EMPTY && acc) ||
          (state == ONE && acc && xfer))
        head <= in_data;
      else if (state == FULL && xfer)
        head <= tail;
      if (state == ONE && acc && !xfer)
        tail <= in_data;
    end
  end
endmodule

// File: rtl/alu_result_stage.sv
// ALU result select, per-beat NZCV flags and the
// architectural flag register, buffered by a skid queue.
import alu_pkg::*;

module alu_result_stage #(
  parameter int DW  = DW_DEF,
  parameter int OPW = OPW_DEF
) (
  input  logic               clk,
  input  logic               rst,
  alu_result_stage_if.slave  io,
  output logic [3:0]         flag_reg
);
  logic [OPW-1:0] op;
  logic [DW-1:0]  sel;
  logic [3:0]     beat_flags;
  logic           acc;
  logic [DW+3:0]  q_data;

  assign op  = io.op_sel;
  assign acc = io.in_valid && io.in_ready;

  always_comb begin
    sel = '0;
    unique case (1'b1)
      (op == OPW'(OP_ADD)): sel = io.add_out;
      (op == OPW'(OP_SUB)): sel = io.sub_out;
      (op == OPW'(OP_AND)): sel = io.and_out;
      (op == OPW'(OP_OR)):  sel = io.or_out;
      (op == OPW'(OP_XOR)): sel = io.xor_out;
      (op == OPW'(OP_SHL)): sel = io.sfl_out;
      (op == OPW'(OP_SHR)): sel = io.sfr_out;
      (op == OPW'(OP_CHK)): sel = io.chk_out;
      default:              sel = '0;
    endcase
  end

  // CHK keeps C/V from the already-committed flag_reg
  always_comb begin
    beat_flags         = '0;
    beat_flags[FLAG_N] = sel[DW-1];
    beat_flags[FLAG_Z] = (sel == '0);
    if (op == OPW'(OP_ADD) || op == OPW'(OP_SUB)) begin
      beat_flags[FLAG_C] = io.cf_in;
      beat_flags[FLAG_V] = io.vf_in;
    end else if (op == OPW'(OP_CHK)) begin
      beat_flags[FLAG_C] = flag_reg[FLAG_C];
      beat_flags[FLAG_V] = flag_reg[FLAG_V];
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      flag_reg <= '0;
    else if (acc && io.set_flags)
      flag_reg <= beat_flags;
  end

  alu_skid_buf #(.W(DW + 4)) u_buf (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (io.in_valid),
    .in_ready  (io.in_ready),
    .in_data   ({beat_flags, sel}),
    .out_valid (io.out_valid),
    .out_ready (io.out_ready),
    .out_data  (q_data)
  );

  assign io.flags_out = q_data[DW+3:DW];
  assign io.result    = q_data[DW-1:0];
endmodule

// File: tb/tb_alu_result_stage.sv
// Directed + short random bench for alu_result_stage
// with a scoreboard of expected result/flag entries.
module tb_alu_result_stage;
  import alu_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] flag_reg;

  alu_result_stage_if #(.DW(32), .OPW(3)) bus ();

  alu_result_stage #(.DW(32), .OPW(3)) dut (
    .clk      (clk),
    .rst      (rst),
    .io       (bus),
    .flag_reg (flag_reg)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] res;
    logic [3:0]  fl;
  } want_t;

  want_t      sb[$];
  logic [3:0] mflag;
  int         n_pass  = 0;
  int         n_total = 0;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] want);
    n_total++;
    assert (obs === want) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h",
                tag, obs, want);
  endtask

  // Scoreboard: pop/compare on transfer, push on accept
  always @(negedge clk) begin : mon
    want_t       w;
    logic [31:0] v;
    logic [3:0]  f;
    if (rst !== 1'b0) begin
      sb.delete();
      mflag = '0;
    end else begin
      chk("flag_reg_model", flag_reg, mflag);
      if (bus.out_valid && bus.out_ready) begin
        chk("sb_nonempty", (sb.size() != 0), 1);
        if (sb.size() != 0) begin
          w = sb.pop_front();
          chk("sb_result", bus.result, w.res);
          chk("sb_flags", bus.flags_out, w.fl);
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        case (bus.op_sel)
          OP_ADD:  v = bus.add_out;
          OP_SUB:  v = bus.sub_out;
          OP_AND:  v = bus.and_out;
          OP_OR:   v = bus.or_out;
          OP_XOR:  v = bus.xor_out;
          OP_SHL:  v = bus.sfl_out;
          OP_SHR:  v = bus.sfr_out;
          default: v = bus.chk_out;
        endcase
        f[3] = v[31];
        f[2] = (v == 32'd0);
        if (bus.op_sel == OP_ADD || bus.op_sel == OP_SUB)
          f[1:0] = {bus.cf_in, bus.vf_in};
        else if (bus.op_sel == OP_CHK)
          f[1:0] = mflag[1:0];
        else
          f[1:0] = 2'b00;
        sb.push_back('{res: v, fl: f});
        if (bus.set_flags) mflag = f;
      end
    end
  end

  task automatic beat(input logic [2:0] op,
                      input logic [31:0] v,
                      input logic cf,
                      input logic vf,
                      input logic sf);
    bus.add_out = $urandom;
    bus.sub_out = $urandom;
    bus.and_out = $urandom;
    bus.or_out  = $urandom;
    bus.xor_out = $urandom;
    bus.sfl_out = $urandom;
    bus.sfr_out = $urandom;
    bus.chk_out = $urandom;
    case (op)
      OP_ADD:  bus.add_out = v;
      OP_SUB:  bus.sub_out = v;
      OP_AND:  bus.and_out = v;
      OP_OR:   bus.or_out  = v;
      OP_XOR:  bus.xor_out = v;
      OP_SHL:  bus.sfl_out = v;
      OP_SHR:  bus.sfr_out = v;
      default: bus.chk_out = v;
    endcase
    bus.op_sel    = op;
    bus.cf_in     = cf;
    bus.vf_in     = vf;
    bus.set_flags = sf;
    bus.in_valid  = 1'b1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst           = 1'b1;
    bus.out_ready = 1'b0;
    beat(OP_ADD, 32'd0, 1'b0, 1'b0, 1'b0);
    bus.in_valid  = 1'b0;
    repeat (3) step();
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_result", bus.result, 0);
    chk("rst_flags_out", bus.flags_out, 0);
    chk("rst_flag_reg", flag_reg, 0);

    rst = 1'b0;
    step();
    chk("post_rst_in_ready", bus.in_ready, 1);
    chk("post_rst_out_valid", bus.out_valid, 0);

    // ADD zero with carry
    bus.out_ready = 1'b1;
    beat(OP_ADD, 32'd0, 1'b1, 1'b0, 1'b1);
    step();
    bus.in_valid = 1'b0;
    chk("add0_out_valid", bus.out_valid, 1);
    chk("add0_result", bus.result, 0);
    chk("add0_flags", bus.flags_out, 4'b0110);
    chk("add0_flag_reg", flag_reg, 4'b0110);
    step();

    // SUB negative with overflow
    beat(OP_SUB, 32'h8000_0000, 1'b0, 1'b1, 1'b1);
    step();
    bus.in_valid = 1'b0;
    chk("sub_result", bus.result, 32'h8000_0000);
    chk("sub_flags", bus.flags_out, 4'b1001);
    step();

    // ADD carry, then CHK back-to-back
    beat(OP_ADD, 32'h10, 1'b1, 1'b0, 1'b1);
    step();
    chk("add_c_flags", bus.flags_out, 4'b0010);
    beat(OP_CHK, 32'd5, 1'b0, 1'b1, 1'b1);
    chk("add_c_flag_reg", flag_reg, 4'b0010);
    step();
    bus.in_valid = 1'b0;
    chk("chk_result", bus.result, 5);
    chk("chk_flags", bus.flags_out, 4'b0010);
    step();
    chk("chk_flag_reg", flag_reg, 4'b0010);

    // XOR zero without set_flags
    beat(OP_XOR, 32'd0, 1'b1, 1'b1, 1'b0);
    step();
    bus.in_valid = 1'b0;
    chk("xor_flags", bus.flags_out, 4'b0100);
    chk("xor_flag_reg", flag_reg, 4'b0010);
    step();

    // Stall: three beats offered, two accepted
    bus.out_ready = 1'b0;
    beat(OP_OR, 32'hA5, 1'b0, 1'b0, 1'b0);
    step();
    chk("stall_rdy_1", bus.in_ready, 1);
    beat(OP_SHL, 32'h8000_0001, 1'b1, 1'b1, 1'b0);
    step();
    chk("stall_rdy_2", bus.in_ready, 0);
    beat(OP_SHR, 32'h3C, 1'b0, 1'b0, 1'b0);
    step();
    chk("stall_rdy_3", bus.in_ready, 0);
    chk("stall_hold_res", bus.result, 32'hA5);
    chk("stall_hold_flags", bus.flags_out, 4'b0000);
    step();
    chk("stall_hold_res2", bus.result, 32'hA5);
    chk("stall_out_valid", bus.out_valid, 1);
    bus.out_ready = 1'b1;
    step();
    chk("rel_res_b", bus.result, 32'h8000_0001);
    chk("rel_flags_b", bus.flags_out, 4'b1000);
    chk("rel_rdy", bus.in_ready, 1);
    step();
    bus.in_valid = 1'b0;
    chk("rel_res_c", bus.result, 32'h3C);
    step();
    chk("rel_drained", bus.out_valid, 0);

    // Reset with queue full
    bus.out_ready = 1'b0;
    beat(OP_ADD, 32'd7, 1'b1, 1'b1, 1'b1);
    step();
    beat(OP_XOR, 32'd9, 1'b0, 1'b0, 1'b0);
    step();
    bus.in_valid = 1'b0;
    chk("full_out_valid", bus.out_valid, 1);
    chk("full_in_ready", bus.in_ready, 0);
    chk("full_flag_reg", flag_reg, 4'b0011);
    rst = 1'b1;
    step();
    chk("mid_rst_out_valid", bus.out_valid, 0);
    chk("mid_rst_in_ready", bus.in_ready, 0);
    chk("mid_rst_flag_reg", flag_reg, 0);
    chk("mid_rst_result", bus.result, 0);
    rst = 1'b0;
    step();
    chk("mid_rst_rdy", bus.in_ready, 1);
    beat(OP_SUB, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b1);
    step();
    bus.in_valid = 1'b0;
    chk("post_rst_res", bus.result, 32'hDEAD_BEEF);
    chk("post_rst_flags", bus.flags_out, 4'b1010);
    chk("post_rst_flag_reg", flag_reg, 4'b1010);
    bus.out_ready = 1'b1;
    step();
    chk("post_rst_drained", bus.out_valid, 0);

    // Random traffic with random backpressure
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 3) != 0)
        beat(3'($urandom_range(0, 7)),
             ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom,
             1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)));
      else
        bus.in_valid = 1'b0;
      bus.out_ready = 1'($urandom_range(0, 1));
      step();
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    repeat (4) step();
    chk("rand_sb_drained", sb.size(), 0);
    chk("rand_out_valid", bus.out_valid, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/alu_result_stage.md
ALU_RESULT_STAGE -- requirements
Module: alu_result_stage

Interface
REQ-001 Parameter: DW, 32, datapath width of all result buses.
REQ-002 Parameter: OPW, 3, width of the operation select.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  upstream presents one operation's function outputs this cycle.
REQ-006 in_ready  output  1  stage can accept a beat.
REQ-007 op_sel  input  OPW  operation code: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SHL, 6 SHR, 7 CHK.
REQ-008 set_flags  input  1  beat updates the architectural flag register.
REQ-009 add_out, sub_out, and_out, or_out, xor_out, sfl_out, sfr_out, chk_out  input  DW each  candidate results from the ALU function block.
REQ-010 cf_in, vf_in  input  1 each  carry and overflow from the function block.
REQ-011 out_valid  output  1  result entry available.
REQ-012 out_ready  input  1  downstream accepts the entry.
REQ-013 result  output  DW  selected result of the head entry.
REQ-014 flags_out  output  4  {N,Z,C,V} captured with the head entry.
REQ-015 flag_reg  output  4  architectural {N,Z,C,V}, committed flags.

Function
REQ-016 Input accept when in_valid && in_ready; output transfer when out_valid && out_ready.
REQ-017 The stage SHALL select result by op_sel from the matching candidate bus, combinationally at accept.
REQ-018 Per-beat flags: Z = (selected result == 0); N = selected result[DW-1].
REQ-019 C and V SHALL equal cf_in/vf_in for ADD and SUB, and 0 for AND, OR, XOR, SHL, SHR.
REQ-020 CHK SHALL update N and Z only; C and V SHALL retain their current flag_reg values.
REQ-021 Buffer: two-entry in-order queue, states EMPTY, ONE, FULL.
REQ-022 EMPTY: accept -> ONE.
REQ-023 ONE: accept without transfer -> FULL; transfer without accept -> EMPTY; both -> ONE, new entry replaces head.
REQ-024 FULL: transfer -> ONE, second entry becomes head; no accept possible.
REQ-025 in_ready SHALL be a registered signal, 1 in EMPTY and ONE, 0 in FULL; no combinational path from out_ready to in_ready.
REQ-026 out_valid SHALL be 1 in ONE and FULL; result/flags_out SHALL be stable while out_valid && !out_ready.
REQ-027 Latency: accepted beat visible on result one cycle after accept when the queue was EMPTY.
REQ-028 flag_reg SHALL update in the cycle after accept when set_flags=1, independent of downstream stall; set_flags=0 leaves it unchanged.
REQ-029 Back-to-back CHK after ADD: CHK's C/V SHALL use flag_reg as already updated by the ADD.
REQ-030 in_valid while in_ready=0: inputs ignored, no state change.

Reset
REQ-031 While rst=1: state EMPTY, out_valid=0, in_ready=0, result=0, flags_out=0, flag_reg=0.
REQ-032 First cycle after rst deasserts: in_ready=1.
REQ-033 rst mid-operation SHALL discard buffered entries; no transfer occurs in the reset cycle.

Structure
REQ-034 Shared package alu_pkg: op_sel encodings, flag bit positions (N=3, Z=2, C=1, V=0), DW default.
REQ-035 One sub-module alu_skid_buf (two-entry queue, DW+4 payload); select/flag logic and flag_reg in the top.

Verification
REQ-036 ADD, add_out=0, cf_in=1, vf_in=0, set_flags=1, out_ready=1 -> next cycle result=0, flags_out=4'b0110, flag_reg=4'b0110.
REQ-037 SUB, sub_out=32'h8000_0000, vf_in=1 -> flags_out=4'b1001.
REQ-038 ADD with cf_in=1 then CHK chk_out=5 -> CHK flags_out=4'b0010.
REQ-039 out_ready=0, three beats offered -> two accepted, in_ready=0 after second, third held; release -> in-order output, third accepted.
REQ-040 set_flags=0 on XOR xor_out=0 -> flags_out Z=1, flag_reg unchanged.
REQ-041 rst asserted with queue FULL -> next cycle out_valid=0, flag_reg=0; first post-reset beat returned intact.
